// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline stage: finalises execute results, derives flags, decodes memory and
// writeback controls and branch redirects, and holds results in a two-entry skid buffer.
package ex_mem_pipe_pkg;
   localparam int unsigned OPC_W  = 7;
   localparam int unsigned REG_W  = 5;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned FLAG_W = 4;

   localparam logic [OPC_W-1:0] OP_NOP  = 7'h00;
   localparam logic [OPC_W-1:0] OP_MOVA = 7'h40;
   localparam logic [OPC_W-1:0] OP_ADD  = 7'h02;
   localparam logic [OPC_W-1:0] OP_SUB  = 7'h05;
   localparam logic [OPC_W-1:0] OP_AND  = 7'h08;
   localparam logic [OPC_W-1:0] OP_OR   = 7'h09;
   localparam logic [OPC_W-1:0] OP_XOR  = 7'h0A;
   localparam logic [OPC_W-1:0] OP_NOT  = 7'h0B;
   localparam logic [OPC_W-1:0] OP_ADI  = 7'h22;
   localparam logic [OPC_W-1:0] OP_SBI  = 7'h25;
   localparam logic [OPC_W-1:0] OP_ANI  = 7'h28;
   localparam logic [OPC_W-1:0] OP_ORI  = 7'h29;
   localparam logic [OPC_W-1:0] OP_XRI  = 7'h2A;
   localparam logic [OPC_W-1:0] OP_AIU  = 7'h62;
   localparam logic [OPC_W-1:0] OP_SIU  = 7'h65;
   localparam logic [OPC_W-1:0] OP_MOVB = 7'h0C;
   localparam logic [OPC_W-1:0] OP_LSR  = 7'h0D;
   localparam logic [OPC_W-1:0] OP_LSL  = 7'h0E;
   localparam logic [OPC_W-1:0] OP_LD   = 7'h10;
   localparam logic [OPC_W-1:0] OP_ST   = 7'h20;
   localparam logic [OPC_W-1:0] OP_JMR  = 7'h70;
   localparam logic [OPC_W-1:0] OP_SLT  = 7'h11;
   localparam logic [OPC_W-1:0] OP_BZ   = 7'h60;
   localparam logic [OPC_W-1:0] OP_BNZ  = 7'h61;
   localparam logic [OPC_W-1:0] OP_JMP  = 7'h44;
   localparam logic [OPC_W-1:0] OP_JML  = 7'h07;

   typedef struct packed {
      logic [OPC_W-1:0]  opcode;
      logic [REG_W-1:0]  rd;
      logic [DATA_W-1:0] result;
      logic [DATA_W-1:0] sdata;
      logic [FLAG_W-1:0] flags;
      logic              regwrite;
      logic              memread;
      logic              memwrite;
   } entry_t;
endpackage

module ex_mem_pipe
   import ex_mem_pipe_pkg::*;
#(
   parameter int unsigned LINK_INC = 4,
   parameter int unsigned DEPTH    = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OPC_W-1:0]  in_opcode,
   input  logic [REG_W-1:0]  in_rd,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   input  logic [DATA_W-1:0] in_fout,
   input  logic              in_carry,
   input  logic [DATA_W-1:0] in_sdata,
   input  logic [DATA_W-1:0] in_pc,
   input  logic [DATA_W-1:0] in_target,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OPC_W-1:0]  out_opcode,
   output logic [REG_W-1:0]  out_rd,
   output logic [DATA_W-1:0] out_result,
   output logic [DATA_W-1:0] out_sdata,
   output logic [FLAG_W-1:0] out_flags,
   output logic              out_regwrite,
   output logic              out_memread,
   output logic              out_memwrite,
   output logic              redirect,
   output logic [DATA_W-1:0] redirect_pc,
   output logic              fwd_valid,
   output logic [REG_W-1:0]  fwd_rd,
   output logic [DATA_W-1:0] fwd_data
);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   entry_t            r_head, r_skid, w_head_nxt, w_skid_nxt, w_new;
   logic              r_head_vld, r_skid_vld, w_head_vld_nxt, w_skid_vld_nxt;
   logic              r_in_ready, r_redirect, r_fwd_valid;
   logic [DATA_W-1:0] r_redirect_pc, w_redirect_pc_nxt, w_take_pc;
   logic              w_redirect_nxt, w_acc, w_pop;
   logic              w_add_cls, w_sub_cls, w_regwrite, w_take, w_v, w_n;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic              w_unused;

   // Only the operand sign bits matter for overflow detection
   assign w_unused = ^{in_a[DATA_W-2:0], in_b[DATA_W-2:0]};

   // Decode, flag derivation and result finalisation of the incoming instruction
   always_comb begin
      w_add_cls  = 1'b0;
      w_sub_cls  = 1'b0;
      w_regwrite = 1'b0;
      w_take     = 1'b0;
      w_take_pc  = in_target;
      case (in_opcode)
         OP_ADD, OP_ADI, OP_AIU: begin
            w_add_cls  = 1'b1;
            w_regwrite = 1'b1;
         end
         OP_SUB, OP_SBI, OP_SIU, OP_SLT: begin
            w_sub_cls  = 1'b1;
            w_regwrite = 1'b1;
         end
         OP_MOVA, OP_MOVB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_ANI, OP_ORI, OP_XRI,
         OP_LSR, OP_LSL, OP_LD: w_regwrite = 1'b1;
         OP_JML: begin
            w_regwrite = 1'b1;
            w_take     = 1'b1;
         end
         OP_JMP: w_take = 1'b1;
         OP_JMR: begin
            w_take    = 1'b1;
            w_take_pc = in_fout;
         end
         OP_BZ, OP_BNZ: w_take = in_fout[0];
         default: ;
      endcase
      w_n = in_fout[DATA_W-1];
      w_v = (w_add_cls & (in_a[DATA_W-1] == in_b[DATA_W-1]) & (in_fout[DATA_W-1] != in_a[DATA_W-1]))
          | (w_sub_cls & (in_a[DATA_W-1] != in_b[DATA_W-1]) & (in_fout[DATA_W-1] != in_a[DATA_W-1]));

      w_new          = '0;
      w_new.opcode   = in_opcode;
      w_new.rd       = in_rd;
      w_new.sdata    = in_sdata;
      w_new.flags    = {w_v, in_carry, w_n, (in_fout == '0)};
      w_new.regwrite = w_regwrite;
      w_new.memread  = (in_opcode == OP_LD);
      w_new.memwrite = (in_opcode == OP_ST);
      if (in_opcode == OP_SLT)
         w_new.result = DATA_W'(w_n ^ w_v);
      else if (in_opcode == OP_JML)
         w_new.result = in_pc + DATA_W'(LINK_INC);
      else
         w_new.result = in_fout;
   end

   assign w_acc = in_valid & r_in_ready & ~flush;
   assign w_pop = r_head_vld & out_ready;

   // Buffer next state: skid refills head on pop, otherwise a new entry fills the first free slot
   always_comb begin
      w_head_nxt     = r_head;
      w_skid_nxt     = r_skid;
      w_head_vld_nxt = r_head_vld;
      w_skid_vld_nxt = r_skid_vld;
      if (flush) begin
         w_head_vld_nxt = 1'b0;
         w_skid_vld_nxt = 1'b0;
      end else if (!r_head_vld || w_pop) begin
         if (r_skid_vld) begin
            w_head_nxt     = r_skid;
            w_head_vld_nxt = 1'b1;
            w_skid_vld_nxt = 1'b0;
         end else if (w_acc) begin
            w_head_nxt     = w_new;
            w_head_vld_nxt = 1'b1;
         end else begin
            w_head_vld_nxt = 1'b0;
         end
      end else if (w_acc) begin
         w_skid_nxt     = w_new;
         w_skid_vld_nxt = 1'b1;
      end
      w_cnt_nxt         = CNT_W'(w_head_vld_nxt) + CNT_W'(w_skid_vld_nxt);
      w_redirect_nxt    = w_acc & w_take;
      w_redirect_pc_nxt = w_redirect_nxt ? w_take_pc : r_redirect_pc;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_head        <= '0;
         r_skid        <= '0;
         r_head_vld    <= 1'b0;
         r_skid_vld    <= 1'b0;
         r_in_ready    <= 1'b1;
         r_redirect    <= 1'b0;
         r_redirect_pc <= '0;
         r_fwd_valid   <= 1'b0;
      end else begin
         r_head        <= w_head_nxt;
         r_skid        <= w_skid_nxt;
         r_head_vld    <= w_head_vld_nxt;
         r_skid_vld    <= w_skid_vld_nxt;
         r_in_ready    <= (w_cnt_nxt < CNT_W'(DEPTH));
         r_redirect    <= w_redirect_nxt;
         r_redirect_pc <= w_redirect_pc_nxt;
         r_fwd_valid   <= w_head_vld_nxt & w_head_nxt.regwrite & (w_head_nxt.rd != '0);
      end
   end

   assign in_ready     = r_in_ready;
   assign out_valid    = r_head_vld;
   assign out_opcode   = r_head.opcode;
   assign out_rd       = r_head.rd;
   assign out_result   = r_head.result;
   assign out_sdata    = r_head.sdata;
   assign out_flags    = r_head.flags;
   assign out_regwrite = r_head.regwrite;
   assign out_memread  = r_head.memread;
   assign out_memwrite = r_head.memwrite;
   assign redirect     = r_redirect;
   assign redirect_pc  = r_redirect_pc;
   assign fwd_valid    = r_fwd_valid;
   assign fwd_rd       = r_head.rd;
   assign fwd_data     = r_head.result;

endmodule
